// File: rtl/rx_ctrl_unit.sv
// Receive control FSM: sequences start, bit reception, stop-bit check and buffer load.
// Keeps sticky framing error and saturating good-packet / error statistics.
module rx_ctrl_unit #(
    parameter int PKT_CNT_BITS = 8,
    parameter int ERR_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start_bit_detected,
    input  logic                    packet_done,
    input  logic                    stop_bit,
    input  logic                    clr_stats,
    output logic                    sbc_clear,
    output logic                    sbc_enable,
    output logic                    enable_timer,
    output logic                    load_buffer,
    output logic                    framing_error,
    output logic [PKT_CNT_BITS-1:0] pkt_count,
    output logic [ERR_CNT_BITS-1:0] err_count
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] RECV     = 3'd2;
    localparam logic [2:0] STOP_CHK = 3'd3;
    localparam logic [2:0] LOAD     = 3'd4;

    logic [2:0] state;
    logic [2:0] next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start_bit_detected) next_state = START;
            START:    next_state = RECV;
            RECV:     if (packet_done) next_state = STOP_CHK;
            STOP_CHK: next_state = stop_bit ? LOAD : IDLE;
            LOAD:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state         <= IDLE;
            framing_error <= 1'b0;
            pkt_count     <= '0;
            err_count     <= '0;
        end else begin
            state <= next_state;

            if (state == START)
                framing_error <= 1'b0;
            else if (state == STOP_CHK && !stop_bit)
                framing_error <= 1'b1;

            // A statistics clear takes priority over any increment in the same cycle.
            if (clr_stats)
                pkt_count <= '0;
            else if (state == LOAD && pkt_count != '1)
                pkt_count <= pkt_count + 1'b1;

            if (clr_stats)
                err_count <= '0;
            else if (state == STOP_CHK && !stop_bit && err_count != '1)
                err_count <= err_count + 1'b1;
        end
    end

    assign sbc_clear    = (state == START);
    assign enable_timer = (state == RECV);
    assign sbc_enable   = (state == STOP_CHK);
    assign load_buffer  = (state == LOAD);

endmodule

// File: tb/tb_rx_ctrl_unit.sv
// Bench for rx_ctrl_unit: directed vector table, hand sequences for reset/abort/saturation,
// and randomized packet traffic checked against an expected-waveform model built per packet.
module tb_rx_ctrl_unit;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start_bit_detected, packet_done, stop_bit, clr_stats;
    logic       sbc_clear, sbc_enable, enable_timer, load_buffer, framing_error;
    logic [7:0] pkt_count;
    logic [3:0] err_count;

    int n_chk  = 0;
    int n_pass = 0;

    rx_ctrl_unit #(.PKT_CNT_BITS(8), .ERR_CNT_BITS(4)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .start_bit_detected (start_bit_detected),
        .packet_done        (packet_done),
        .stop_bit           (stop_bit),
        .clr_stats          (clr_stats),
        .sbc_clear          (sbc_clear),
        .sbc_enable         (sbc_enable),
        .enable_timer       (enable_timer),
        .load_buffer        (load_buffer),
        .framing_error      (framing_error),
        .pkt_count          (pkt_count),
        .err_count          (err_count)
    );

    always #5 clk = ~clk;

    // {sbc_clear, sbc_enable, enable_timer, load_buffer, framing_error}
    function automatic logic [4:0] outs();
        return {sbc_clear, sbc_enable, enable_timer, load_buffer, framing_error};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One packet from IDLE: L RECV cycles, stop bit value st, clr_stats during LOAD.
    task automatic send(input int len, input bit st, input bit clr_ld);
        start_bit_detected = 1'b1; step();
        start_bit_detected = 1'b0; step();
        repeat (len - 1) step();
        packet_done = 1'b1; step();
        packet_done = 1'b0; stop_bit = st; step();
        stop_bit = 1'b0;
        if (st) begin
            clr_stats = clr_ld; step();
            clr_stats = 1'b0;
        end
    endtask

    typedef struct {
        bit         sd, pd, sb, cs;
        logic [4:0] o;
        int         pkt, err;
    } vec_t;

    function automatic vec_t mk(bit sd, bit pd, bit sb, bit cs, logic [4:0] o, int pkt, int err);
        vec_t v;
        v.sd = sd; v.pd = pd; v.sb = sb; v.cs = cs; v.o = o; v.pkt = pkt; v.err = err;
        return v;
    endfunction

    localparam int NC = 1500;
    bit start_at[NC], busy[NC], in_recv[NC], pdone[NC], chk_at[NC], stop_v[NC];
    bit ld_at[NC], err_inc[NC], fe_set[NC], fe_clr[NC], clr_at[NC];
    bit sd_a[NC], pd_a[NC], sb_a[NC], cs_a[NC];
    logic [4:0] e_o[NC];
    int e_pkt[NC], e_err[NC];

    initial begin : main
        vec_t tbl[16];
        int cur, s, len, fin;
        bit st, fe;

        n_rst = 1'b0; start_bit_detected = 1'b1; packet_done = 1'b0;
        stop_bit = 1'b0; clr_stats = 1'b0;

        // Reset held for two edges with a start pulse present: nothing may leave IDLE.
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset_outs", outs(), 5'b0);
            check("reset_pkt", pkt_count, 0);
            check("reset_err", err_count, 0);
        end
        start_bit_detected = 1'b0;
        n_rst = 1'b1;

        // Good packet with 10 RECV cycles, ignored strobes, back-to-back restart.
        tbl[0]  = mk(1, 0, 0, 0, 5'b00000, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 5'b10000, 0, 0);
        for (int i = 2; i <= 10; i++) tbl[i] = mk(i == 5, 0, 0, 0, 5'b00100, 0, 0);
        tbl[11] = mk(0, 1, 0, 0, 5'b00100, 0, 0);
        tbl[12] = mk(0, 0, 1, 0, 5'b01000, 0, 0);
        tbl[13] = mk(0, 1, 0, 0, 5'b00010, 0, 0);
        tbl[14] = mk(1, 0, 0, 0, 5'b00000, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 5'b10000, 1, 0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tbl%0d_outs", i), outs(), tbl[i].o);
            check($sformatf("tbl%0d_pkt", i), pkt_count, tbl[i].pkt);
            check($sformatf("tbl%0d_err", i), err_count, tbl[i].err);
            start_bit_detected = tbl[i].sd; packet_done = tbl[i].pd;
            stop_bit = tbl[i].sb; clr_stats = tbl[i].cs;
            step();
        end
        start_bit_detected = 1'b0; packet_done = 1'b0; stop_bit = 1'b0;

        // Now in RECV: a start pulse is ignored, then reset aborts the packet.
        check("recv_entered", outs(), 5'b00100);
        start_bit_detected = 1'b1; step();
        start_bit_detected = 1'b0;
        check("recv_start_ignored", outs(), 5'b00100);
        n_rst = 1'b0;
        #3;
        check("reset_waits_for_edge", outs(), 5'b00100);
        check("reset_waits_pkt", pkt_count, 1);
        step();
        check("abort_outs", outs(), 5'b0);
        check("abort_pkt", pkt_count, 0);
        n_rst = 1'b1;
        packet_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            packet_done = 1'b0;
            check("abort_stays_idle", outs(), 5'b0);
        end

        // Saturation of err_count, then recovery and clear-vs-increment priority.
        for (int i = 0; i < 16; i++) send(1, 1'b0, 1'b0);
        check("err_saturated", err_count, 15);
        check("fe_after_bad", framing_error, 1'b1);
        check("no_pkt_on_bad", pkt_count, 0);
        send(3, 1'b1, 1'b0);
        check("fe_cleared_by_good", framing_error, 1'b0);
        check("pkt_one", pkt_count, 1);
        check("err_held", err_count, 15);
        send(2, 1'b1, 1'b1);
        check("clr_wins_pkt", pkt_count, 0);
        check("clr_err", err_count, 0);

        // Randomized traffic: build per-packet schedule and expected waveform.
        cur = 0;
        while (1) begin
            s   = cur + $urandom_range(0, 3);
            len = $urandom_range(1, 12);
            st  = ($urandom_range(0, 2) != 0);
            fin = s + 3 + len + (st ? 1 : 0);
            if (fin + 2 >= NC) break;
            start_at[s] = 1'b1;
            fe_clr[s + 2] = 1'b1;
            for (int c = s + 1; c < fin; c++) busy[c] = 1'b1;
            for (int c = s + 2; c <= s + 1 + len; c++) in_recv[c] = 1'b1;
            pdone[s + 1 + len] = 1'b1;
            chk_at[s + 2 + len] = 1'b1;
            stop_v[s + 2 + len] = st;
            if (st) ld_at[s + 3 + len] = 1'b1;
            else begin
                err_inc[s + 2 + len] = 1'b1;
                fe_set[s + 3 + len] = 1'b1;
            end
            cur = fin;
        end
        fe = 1'b0;
        for (int c = 0; c < NC; c++) begin
            sd_a[c] = start_at[c] | (busy[c] & ($urandom_range(0, 3) == 0));
            pd_a[c] = pdone[c] | (!in_recv[c] & ($urandom_range(0, 2) == 0));
            sb_a[c] = chk_at[c] ? stop_v[c] : 1'($urandom_range(0, 1));
            cs_a[c] = ($urandom_range(0, 39) == 0);
            if (fe_set[c]) fe = 1'b1;
            else if (fe_clr[c]) fe = 1'b0;
            e_o[c] = {start_at[c > 0 ? c - 1 : 0] & (c > 0), chk_at[c], in_recv[c], ld_at[c], fe};
            if (c == 0) begin
                e_pkt[c] = 0; e_err[c] = 0;
            end else begin
                e_pkt[c] = cs_a[c-1] ? 0 : (ld_at[c-1] ? ((e_pkt[c-1] + 1 > 255) ? 255 : e_pkt[c-1] + 1) : e_pkt[c-1]);
                e_err[c] = cs_a[c-1] ? 0 : (err_inc[c-1] ? ((e_err[c-1] + 1 > 15) ? 15 : e_err[c-1] + 1) : e_err[c-1]);
            end
        end

        n_rst = 1'b0; step(); step();
        n_rst = 1'b1;
        for (int c = 0; c < NC; c++) begin
            check($sformatf("rand_c%0d", c), {outs(), pkt_count, err_count},
                  {e_o[c], 8'(e_pkt[c]), 4'(e_err[c])});
            start_bit_detected = sd_a[c]; packet_done = pd_a[c];
            stop_bit = sb_a[c]; clr_stats = cs_a[c];
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
